// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: round-robin grant,
// one operation in flight, registered response held until its owner consumes it.
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_ctrl,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_ctrl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_res,
  input  logic [3:0]  alu_flags,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_res,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic        prio;
  logic        owner;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  op_ctrl;
  logic        grant_any;
  logic        grant_id;
  logic        legal;
  logic        rsp_done;

  // prio only breaks ties; a lone requester always wins
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (state == IDLE && !reset) begin
      if (req0_valid && req1_valid) begin
        grant_any = 1'b1;
        grant_id  = prio;
      end else if (req0_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  always_comb begin
    case (op_ctrl)
      4'b0000, 4'b0010, 4'b0100, 4'b0101,
      4'b0110, 4'b0111, 4'b1010: legal = 1'b1;
      default:                   legal = 1'b0;
    endcase
  end

  assign req0_ready = grant_any && !grant_id;
  assign req1_ready = grant_any && grant_id;

  assign alu_a    = (state == EXEC) ? op_a    : 32'd0;
  assign alu_b    = (state == EXEC) ? op_b    : 32'd0;
  assign alu_ctrl = (state == EXEC) ? op_ctrl : 4'd0;

  assign rsp0_valid = (state == RESP) && !owner && !reset;
  assign rsp1_valid = (state == RESP) && owner && !reset;
  assign rsp_done   = owner ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prio      <= 1'b0;
      owner     <= 1'b0;
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      op_ctrl   <= 4'd0;
      rsp_res   <= 32'd0;
      rsp_flags <= 4'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_a    <= grant_id ? req1_a    : req0_a;
            op_b    <= grant_id ? req1_b    : req0_b;
            op_ctrl <= grant_id ? req1_ctrl : req0_ctrl;
            owner   <= grant_id;
            prio    <= ~grant_id;
            state   <= EXEC;
          end
        end
        EXEC: begin
          // illegal opcodes still take the EXEC slot but report a zeroed result
          rsp_res   <= legal ? alu_res   : 32'd0;
          rsp_flags <= legal ? alu_flags : 4'd0;
          rsp_err   <= ~legal;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter: the driver predicts grants and
// queues expected responses, a negedge monitor pops and compares them.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_ctrl = '0, req1_ctrl = '0;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_ctrl, alu_flags;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp_res;
  logic [3:0]  rsp_flags;
  logic        rsp_err;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_res(alu_res), .alu_flags(alu_flags),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Behavioural ALU returning {negative, zero, carry, overflow, result}.
  // Undefined opcodes return junk so a missing zeroing in the DUT shows up.
  function automatic logic [35:0] aluModel(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    logic [32:0] s;
    logic [31:0] r;
    logic cy, ov;
    s = '0; r = '0; cy = 1'b0; ov = 1'b0;
    case (c)
      4'b0000: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; cy = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'b0010: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; cy = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = a ^ b;
      4'b0111: r = ~(a | b);
      4'b1010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return {4'hF, a ^ b ^ 32'hDEADBEEF};
    endcase
    return {r[31], (r == 32'd0), cy, ov, r};
  endfunction

  assign {alu_flags, alu_res} = aluModel(alu_a, alu_b, alu_ctrl);

  typedef struct {
    int          owner;
    int          grantCyc;
    logic [31:0] res;
    logic [3:0]  flags;
    logic        err;
  } expT;

  localparam int NEVER = 32'h7FFF_FFFF;

  expT         sbQ[$];
  expT         curExp;
  bit          holding = 1'b0;
  int          cyc = 0;
  int          idleFrom = NEVER;
  int          checks = 0;
  int          failures = 0;
  int          lastGrant = 1;
  int          rspHold = 0;
  bit          pending[2] = '{1'b0, 1'b0};
  logic [31:0] opA[2], opB[2];
  logic [3:0]  opC[2];
  bit          execPending = 1'b0;
  logic [31:0] execA, execB;
  logic [3:0]  execC;
  logic [3:0]  legalOps[7]   = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1010};
  logic [3:0]  illegalOps[9] = '{4'b0001, 4'b0011, 4'b1000, 4'b1001, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: legal ops forward the ALU outcome, anything else is a zeroed error response.
  function automatic expT predict(input int owner, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    expT e;
    logic [35:0] m;
    e.owner = owner;
    e.grantCyc = cyc;
    if (c inside {4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1010}) begin
      m = aluModel(a, b, c);
      e.res = m[31:0]; e.flags = m[35:32]; e.err = 1'b0;
    end else begin
      e.res = '0; e.flags = '0; e.err = 1'b1;
    end
    return e;
  endfunction

  task automatic setOp(input int n, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    pending[n] = 1'b1;
    opA[n] = a; opB[n] = b; opC[n] = c;
  endtask

  task automatic newRandomOp(input int n);
    logic [3:0] c;
    if ($urandom_range(0, 7) == 0) c = illegalOps[$urandom_range(0, 8)];
    else c = legalOps[$urandom_range(0, 6)];
    setOp(n, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : 32'($urandom),
          ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : 32'($urandom), c);
  endtask

  // One clock: drive after the edge, predict grant and check at the negedge.
  task automatic applyStimulus(input bit randomNew, input bit randomRdy, input bit doReset);
    int g;
    @(posedge clk);
    #1;
    reset = doReset;
    if (doReset) begin
      sbQ.delete();
      holding = 1'b0;
      execPending = 1'b0;
      lastGrant = 1;
      idleFrom = cyc + 1;
    end
    if (randomNew) begin
      for (int n = 0; n < 2; n++) begin
        if (!pending[n] && $urandom_range(0, 2) == 0) newRandomOp(n);
        else if (pending[n] && $urandom_range(0, 15) == 0) pending[n] = 1'b0;
      end
    end
    req0_valid = pending[0]; req0_a = opA[0]; req0_b = opB[0]; req0_ctrl = opC[0];
    req1_valid = pending[1]; req1_a = opA[1]; req1_b = opB[1]; req1_ctrl = opC[1];
    if (rspHold > 0 && (rsp0_valid || rsp1_valid)) begin
      rsp0_ready = 1'b0; rsp1_ready = 1'b0; rspHold--;
    end else if (randomRdy) begin
      rsp0_ready = 1'($urandom_range(0, 1)); rsp1_ready = 1'($urandom_range(0, 1));
    end else begin
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    end
    @(negedge clk);
    if (reset) begin
      checkOutput("ready_in_reset", {req1_ready, req0_ready}, 2'b00);
      checkOutput("rsp_valid_in_reset", {rsp1_valid, rsp0_valid}, 2'b00);
      return;
    end
    if (execPending) begin
      checkOutput("alu_a_exec", alu_a, execA);
      checkOutput("alu_b_exec", alu_b, execB);
      checkOutput("alu_ctrl_exec", alu_ctrl, execC);
      execPending = 1'b0;
    end
    if (cyc >= idleFrom) begin
      checkOutput("alu_zero_idle", {alu_a, alu_b, alu_ctrl}, 68'd0);
    end
    if (cyc >= idleFrom && (pending[0] || pending[1])) begin
      if (pending[0] && pending[1]) g = 1 - lastGrant;
      else g = pending[1] ? 1 : 0;
      checkOutput("grant_ready", {req1_ready, req0_ready}, (g == 1) ? 2'b10 : 2'b01);
      lastGrant = g;
      sbQ.push_back(predict(g, opA[g], opB[g], opC[g]));
      execA = opA[g]; execB = opB[g]; execC = opC[g];
      execPending = 1'b1;
      idleFrom = NEVER;
      pending[g] = 1'b0;
    end else begin
      checkOutput("ready_low", {req1_ready, req0_ready}, 2'b00);
    end
  endtask

  task automatic drain(input bit rnd, input int budget);
    int n;
    n = 0;
    while ((pending[0] || pending[1] || sbQ.size() != 0 || holding) && n < budget) begin
      applyStimulus(1'b0, rnd, 1'b0);
      n++;
    end
    checkOutput("drain_done", (n < budget), 1);
  endtask

  // Monitor: pops an expectation when a response appears and re-checks it each held cycle.
  always @(negedge clk) begin
    if (!reset && (rsp0_valid || rsp1_valid)) begin
      if (!holding) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
        end else begin
          curExp = sbQ.pop_front();
          holding = 1'b1;
          checkOutput("rsp_latency", cyc, curExp.grantCyc + 2);
        end
      end
      if (holding) begin
        checkOutput("rsp_owner", {rsp1_valid, rsp0_valid}, (curExp.owner == 1) ? 2'b10 : 2'b01);
        checkOutput("rsp_res", rsp_res, curExp.res);
        checkOutput("rsp_flags", rsp_flags, curExp.flags);
        checkOutput("rsp_err", rsp_err, curExp.err);
        checkOutput("alu_zero_resp", {alu_a, alu_b, alu_ctrl}, 68'd0);
        if ((curExp.owner == 0 && rsp0_ready) || (curExp.owner == 1 && rsp1_ready)) begin
          holding = 1'b0;
          idleFrom = cyc + 1;
        end
      end
    end
  end

  initial begin
    $display("[TB] starting alu_arbiter bench");
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("reset_rsp_res", rsp_res, 32'd0);
    checkOutput("reset_rsp_flags", rsp_flags, 4'd0);
    checkOutput("reset_rsp_err", rsp_err, 1'b0);
    checkOutput("reset_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    checkOutput("reset_alu", {alu_a, alu_b, alu_ctrl}, 68'd0);

    setOp(0, 32'd5, 32'd7, 4'b0000);
    drain(1'b0, 20);

    applyStimulus(1'b0, 1'b0, 1'b1);
    setOp(0, 32'd3, 32'd3, 4'b0010);
    setOp(1, 32'hFFFF_FFFF, 32'd1, 4'b1010);
    drain(1'b0, 30);

    setOp(1, 32'h7FFF_FFFF, 32'd1, 4'b0000);
    rspHold = 5;
    applyStimulus(1'b0, 1'b0, 1'b0);
    setOp(0, 32'd10, 32'd20, 4'b0110);
    drain(1'b0, 40);

    setOp(0, 32'h1234, 32'h5678, 4'b0011);
    drain(1'b0, 20);

    setOp(0, 32'd9, 32'd4, 4'b0010);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    setOp(0, 32'd1, 32'd2, 4'b0000);
    setOp(1, 32'd3, 32'd4, 4'b0101);
    drain(1'b0, 30);

    for (int i = 0; i < 800; i++) begin
      applyStimulus(1'b1, 1'b1, ($urandom_range(0, 99) == 0));
    end
    drain(1'b1, 300);
    checkOutput("scoreboard_empty", sbQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
